// File: rtl/rnn_cell_mm.sv
// Elman RNN cell accelerator: h' = act(b + Wx*x + Wh*h) over a word-addressed slave port.
// Sequential datapath with one multiply-accumulate per cycle; H is replaced only at COMMIT.
//
// state  | meaning
// IDLE   | waiting for start, host writes accepted
// ROW    | acc = (B[i] <<< FRAC) + WX[i]*X
// MAC    | acc += WH[i][j]*H[j], j = 0..HIDDEN-1
// WB     | HN[i] = act(acc >>> FRAC), advance row
// COMMIT | H = HN, raise done
module rnn_cell_mm #(
  parameter int HIDDEN = 4,
  parameter int DATA_W = 16,
  parameter int FRAC   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int IDX_W  = (HIDDEN > 1) ? $clog2(HIDDEN) : 1;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(HIDDEN + 2);

  localparam logic signed [ACC_W-1:0] TANH_HI = ACC_W'(1 << FRAC);
  localparam logic signed [ACC_W-1:0] TANH_LO = ACC_W'(-(1 << FRAC));
  localparam logic signed [ACC_W-1:0] RELU_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ZERO    = '0;

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_MAC, S_WB, S_COMMIT} state_t;

  state_t                     state_q, state_d;
  logic        [IDX_W-1:0]    row_q, row_d;
  logic        [IDX_W-1:0]    col_q, col_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       mode_q, mode_d;
  logic                       done_q, done_d;
  logic signed [DATA_W-1:0]   x_q, x_d;
  logic signed [DATA_W-1:0]   h_q  [HIDDEN];
  logic signed [DATA_W-1:0]   h_d  [HIDDEN];
  logic signed [DATA_W-1:0]   hn_q [HIDDEN];
  logic signed [DATA_W-1:0]   hn_d [HIDDEN];
  logic signed [DATA_W-1:0]   wx_q [HIDDEN];
  logic signed [DATA_W-1:0]   wx_d [HIDDEN];
  logic signed [DATA_W-1:0]   b_q  [HIDDEN];
  logic signed [DATA_W-1:0]   b_d  [HIDDEN];
  logic signed [DATA_W-1:0]   wh_q [HIDDEN][HIDDEN];
  logic signed [DATA_W-1:0]   wh_d [HIDDEN][HIDDEN];
  logic        [31:0]         data_out_q, data_out_d;

  logic                       busy;
  logic        [11:0]         a12;
  logic signed [DATA_W-1:0]   wdat;
  logic        [31:0]         rdata;
  logic signed [PROD_W-1:0]   prod_x;
  logic signed [PROD_W-1:0]   prod_h;
  logic signed [ACC_W-1:0]    b_ext;
  logic                       unused_bits;

  assign busy        = (state_q != S_IDLE);
  assign a12         = addr[11:0];
  assign wdat        = data_in[DATA_W-1:0];
  assign data_out    = data_out_q;
  assign unused_bits = ^{addr[31:12], data_in[31:DATA_W]};

  assign prod_x = PROD_W'(wx_q[row_q]) * PROD_W'(x_q);
  assign prod_h = PROD_W'(wh_q[row_q][col_q]) * PROD_W'(h_q[col_q]);
  assign b_ext  = ACC_W'(b_q[row_q]) <<< FRAC;

  function automatic logic [31:0] sext(input logic signed [DATA_W-1:0] v);
    return {{(32 - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Arithmetic shift floors; the clamp bounds depend on the latched mode.
  function automatic logic signed [DATA_W-1:0] act(input logic signed [ACC_W-1:0] a,
                                                   input logic relu);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (relu) begin
      if (s < ZERO)         s = ZERO;
      else if (s > RELU_HI) s = RELU_HI;
    end else begin
      if (s > TANH_HI)      s = TANH_HI;
      else if (s < TANH_LO) s = TANH_LO;
    end
    return s[DATA_W-1:0];
  endfunction

  always_comb begin
    rdata = '0;
    if (a12 == 12'h000) rdata = {29'd0, mode_q, done_q, busy};
    if (a12 == 12'h001) rdata = sext(x_q);
    for (int i = 0; i < HIDDEN; i++) begin
      if (a12 == 12'(2 + i))     rdata = sext(h_q[i]);
      if (a12 == 12'(256 + i))   rdata = sext(wx_q[i]);
      if (a12 == 12'(768 + i))   rdata = sext(b_q[i]);
      for (int j = 0; j < HIDDEN; j++) begin
        if (a12 == 12'(512 + 16 * i + j)) rdata = sext(wh_q[i][j]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    acc_d      = acc_q;
    mode_d     = mode_q;
    done_d     = done_q;
    x_d        = x_q;
    h_d        = h_q;
    hn_d       = hn_q;
    wx_d       = wx_q;
    b_d        = b_q;
    wh_d       = wh_q;
    data_out_d = read ? rdata : data_out_q;

    if (write && !busy) begin
      if (a12 == 12'h001) x_d = wdat;
      for (int i = 0; i < HIDDEN; i++) begin
        if (a12 == 12'(2 + i))   h_d[i]  = wdat;
        if (a12 == 12'(256 + i)) wx_d[i] = wdat;
        if (a12 == 12'(768 + i)) b_d[i]  = wdat;
        for (int j = 0; j < HIDDEN; j++) begin
          if (a12 == 12'(512 + 16 * i + j)) wh_d[i][j] = wdat;
        end
      end
      if (a12 == 12'h000) begin
        mode_d = data_in[2];
        // Clear lands before the step begins, so a start+clear runs with h = 0.
        if (data_in[1]) begin
          for (int i = 0; i < HIDDEN; i++) h_d[i] = '0;
        end
        if (data_in[0]) begin
          state_d = S_ROW;
          row_d   = '0;
          done_d  = 1'b0;
        end
      end
    end

    case (state_q)
      S_ROW: begin
        acc_d   = b_ext + ACC_W'(prod_x);
        col_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = acc_q + ACC_W'(prod_h);
        col_d = col_q + 1'b1;
        if (col_q == IDX_W'(HIDDEN - 1)) state_d = S_WB;
      end
      S_WB: begin
        hn_d[row_q] = act(acc_q, mode_q);
        if (row_q == IDX_W'(HIDDEN - 1)) begin
          state_d = S_COMMIT;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = S_ROW;
        end
      end
      S_COMMIT: begin
        h_d     = hn_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      acc_q      <= '0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
      x_q        <= '0;
      h_q        <= '{default: '0};
      hn_q       <= '{default: '0};
      wx_q       <= '{default: '0};
      b_q        <= '{default: '0};
      wh_q       <= '{default: '{default: '0}};
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      done_q     <= done_d;
      x_q        <= x_d;
      h_q        <= h_d;
      hn_q       <= hn_d;
      wx_q       <= wx_d;
      b_q        <= b_d;
      wh_q       <= wh_d;
      data_out_q <= data_out_d;
    end
  end

endmodule
